mul_div_unit: RTL and testbench

- Iterative 32-bit multiply/divide execution unit implementing the RV32M operations.
- Sits directly downstream of the register file: consumes the RD1 and RD2 operand pair.
- Sits upstream of the write-back path: its result and destination index drive WD3/A3, and done drives WE3 through the write-back mux.
- Multi-cycle, with a start/busy/done handshake; the core stalls while busy is high.

---
 rtl/mdu_pkg.sv | 15 +
 rtl/mdu_operand_prep.sv | 33 +++
 rtl/mul_div_unit.sv | 132 +++++++++++++
 tb/tb_mul_div_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM state type and fixed result constants for mul_div_unit.
package mdu_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;
    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
endpackage

// File: rtl/mdu_operand_prep.sv
// mdu_operand_prep: per-op operand magnitudes, result sign flags and
// divide-by-zero / signed-overflow detection with their fixed results.
module mdu_operand_prep #(
    parameter int XLEN = mdu_pkg::XLEN
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] abs_a,
    output logic [XLEN-1:0] abs_b,
    output logic [XLEN-1:0] spec_res,
    output logic            neg_res,
    output logic            neg_rem,
    output logic            special
);
    import mdu_pkg::*;
    logic a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
    always_comb begin
        a_sgn    = op == MDU_MULH || op == MDU_MULHSU || op == MDU_DIV || op == MDU_REM;
        b_sgn    = op == MDU_MULH || op == MDU_DIV || op == MDU_REM;
        a_neg    = a_sgn && src_a[XLEN-1];
        b_neg    = b_sgn && src_b[XLEN-1];
        abs_a    = a_neg ? -src_a : src_a;
        abs_b    = b_neg ? -src_b : src_b;
        neg_res  = a_neg ^ b_neg;
        neg_rem  = a_neg;
        div0     = src_b == '0;
        ovf      = b_sgn && op[2] && src_a == INT_MIN && src_b == '1;
        special  = op[2] && (div0 || ovf);
        // op[1] separates REM/REMU from DIV/DIVU
        spec_res = op[1] ? (div0 ? src_a : '0) : (div0 ? DIV0_QUOT : INT_MIN);
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply (shift-add) / divide (restoring), one bit per cycle.
// Define MDU_EARLY_OUT_EN to end multiplies once the remaining multiplier bits are all zero.
module mul_div_unit #(
    parameter int XLEN  = mdu_pkg::XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    import mdu_pkg::*;
    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d, rd_out_q, rd_out_d;
    logic [XLEN-1:0]   m_q, m_d, result_q, result_d;
    logic [2*XLEN-1:0] p_q, p_d, p_calc, pf, prod_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d, negr_q, negr_d, spec_q, spec_d, done_q, done_d;
    logic [XLEN:0]     sum;
    logic [XLEN+1:0]   diff;
    logic [XLEN-1:0]   abs_a, abs_b, spec_res, quo_s, rem_s, fix_res;
    logic              p_neg, p_negr, p_spec, accept, last;

    mdu_operand_prep #(.XLEN(XLEN)) u_prep (
        .op(op), .src_a(src_a), .src_b(src_b), .abs_a(abs_a), .abs_b(abs_b),
        .spec_res(spec_res), .neg_res(p_neg), .neg_rem(p_negr), .special(p_spec)
    );

    // special cases pass through FIX for one cycle without raising busy
    assign busy   = state_q == CALC || (state_q == FIX && !spec_q);
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;

    always_comb begin
        sum    = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, m_q};
        diff   = {1'b0, p_q[2*XLEN-1:XLEN-1]} - {2'b0, m_q};
        p_calc = op_q[2] ? (diff[XLEN+1] ? {p_q[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1})
                         : (p_q[0] ? {sum, p_q[XLEN-1:1]} : {1'b0, p_q[2*XLEN-1:1]});
        last   = cnt_q == CNT_W'(XLEN - 1);
        pf     = p_q;
`ifdef MDU_EARLY_OUT_EN
        // unconsumed multiplier bits sit below the partial product; an early exit leaves it un-aligned
        last   = last || (!op_q[2] && (p_calc[XLEN-1:0] & ({XLEN{1'b1}} >> (cnt_q + CNT_W'(1)))) == '0);
        pf     = op_q[2] ? p_q : p_q >> (CNT_W'(XLEN - 1) - cnt_q);
`endif
        prod_s  = neg_q ? -pf : pf;
        quo_s   = neg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
        rem_s   = negr_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
        fix_res = spec_q ? p_q[XLEN-1:0] : op_q == MDU_MUL ? prod_s[XLEN-1:0] :
                  !op_q[2] ? prod_s[2*XLEN-1:XLEN] : op_q[1] ? rem_s : quo_s;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rd_out_d = rd_out_q;
        m_d      = m_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        spec_d   = spec_q;
        result_d = result_q;
        done_d   = 1'b0;
        accept   = start && !busy;
        case (state_q)
            CALC: begin
                p_d     = p_calc;
                cnt_d   = last ? cnt_q : cnt_q + CNT_W'(1);
                state_d = last ? FIX : CALC;
            end
            FIX: begin
                result_d = fix_res;
                rd_out_d = rd_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: ;
        endcase
        if (accept) begin
            op_d    = op;
            rd_d    = rd_in;
            m_d     = op[2] ? abs_b : abs_a;
            p_d     = {{XLEN{1'b0}}, p_spec ? spec_res : op[2] ? abs_a : abs_b};
            cnt_d   = '0;
            neg_d   = p_neg;
            negr_d  = p_negr;
            spec_d  = p_spec;
            state_d = p_spec ? FIX : CALC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            m_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            spec_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            m_q      <= m_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            spec_q   <= spec_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized RV32M checks against a 64-bit arithmetic reference model.
module tb_mul_div_unit;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] src_a = '0, src_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    int          checks = 0, errors = 0;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        logic        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        int          k = 0;
        if (o[2] && (b == 0 || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        m = (o == 3'd1 && b[31]) ? -b : b;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
`ifdef MDU_EARLY_OUT_EN
        if (!o[2]) return (k < 1 ? 1 : k) + 1;
`endif
        return 33 + 0 * k;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            4: return -$urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int glitch, input bit hold);
        logic [31:0] exp = ref_mdu(o, a, b);
        int          lat = ref_lat(o, a, b);
        int          n = 0;
        bit          bad_busy = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; rd_in = rd;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom; rd_in = 5'($urandom);
        while (done !== 1'b1 && n < 100) begin
            if (busy !== (lat > 1)) bad_busy = 1'b1;
            if (n == glitch) begin
                start = 1'b1; op = 3'($urandom); src_a = $urandom; src_b = $urandom; rd_in = 5'($urandom);
            end else start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check($sformatf("latency op%0d %h/%h", o, a, b), 32'(n), 32'(lat));
        check($sformatf("busy op%0d", o), {30'b0, busy, bad_busy}, 32'h0);
        check($sformatf("result op%0d %h,%h", o, a, b), result, exp);
        check($sformatf("rd_out op%0d", o), {27'b0, rd_out}, {27'b0, rd});
        if (hold) begin
            @(posedge clk); #1;
            check("done pulse width", {31'b0, done}, 32'h0);
            check("result hold", result, exp);
            check("rd_out hold", {27'b0, rd_out}, {27'b0, rd});
        end
    endtask

    initial begin
        bit saw_done = 1'b0;
        #12;
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        check("reset result", result, 32'h0);
        check("reset rd_out", {27'b0, rd_out}, 32'h0);
        @(negedge clk); rst = 1'b0;

        run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, -1, 1'b1);
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, -1, 1'b0);
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, -1, 1'b0);
        run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, -1, 1'b1);
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, -1, 1'b0);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, -1, 1'b0);
        run(3'd5, 32'd100, 32'd7, 5'd7, -1, 1'b0);
        run(3'd7, 32'd100, 32'd7, 5'd8, -1, 1'b1);
        run(3'd4, 32'd5, 32'd0, 5'd9, -1, 1'b1);
        run(3'd7, 32'h1234, 32'd0, 5'd10, -1, 1'b0);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, -1, 1'b0);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, -1, 1'b1);
        run(3'd0, 32'h1234_5678, 32'd3, 5'd13, -1, 1'b1);
        run(3'd5, 32'd1000, 32'd9, 5'd14, 5, 1'b1);

        @(negedge clk);
        start = 1'b1; op = 3'd0; src_a = 32'd12345; src_b = 32'd678; rd_in = 5'd15;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst = 1'b1; #1;
        check("abort busy", {31'b0, busy}, 32'h0);
        check("abort done", {31'b0, done}, 32'h0);
        check("abort result", result, 32'h0);
        check("abort rd_out", {27'b0, rd_out}, 32'h0);
        @(negedge clk); rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort no done", {31'b0, saw_done}, 32'h0);
        run(3'd0, 32'd6, 32'd7, 5'd16, -1, 1'b1);

        for (int i = 0; i < 40; i++)
            run(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), -1, 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
